// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Uses shift-add multiply and restoring divide, one iteration per clock, then a
// fix-up cycle that applies signs and the MADD/MSUB accumulate before writing
// HI/LO. Busy stalls the pipeline while an operation is in flight.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMadd  = 3'b010;
  localparam logic [2:0] OpMsub  = 3'b011;
  localparam logic [2:0] OpDiv   = 3'b100;
  localparam logic [2:0] OpDivu  = 3'b101;
  localparam logic [2:0] OpMthi  = 3'b110;
  localparam logic [2:0] OpMtlo  = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   opa_q;      // multiplicand magnitude
  logic [WIDTH-1:0]   opb_q;      // divisor magnitude
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] base_q;     // {HI,LO} snapshot for MADD/MSUB
  logic               neg_q;      // product / quotient must be negated
  logic               rneg_q;     // remainder must be negated (dividend was negative)

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               is_div_q;

  assign Busy     = (state_q != StIdle);
  assign is_div_q = (op_q == OpDiv) || (op_q == OpDivu);

  // Operand magnitudes, one iteration step of each algorithm, and fix-up results.
  always_comb begin
    signed_op = (Op == OpMult) || (Op == OpMadd) || (Op == OpMsub) || (Op == OpDiv);
    abs_a     = (signed_op && A[WIDTH-1]) ? -A : A;
    abs_b     = (signed_op && B[WIDTH-1]) ? -B : B;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};

    prod      = neg_q ? -acc_q : acc_q;
    unique case (op_q)
      OpMadd:  mul_res = base_q + prod;
      OpMsub:  mul_res = base_q - prod;
      default: mul_res = prod;
    endcase

    quo = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM with registered HI/LO, Done and DivByZero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      base_q    <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      HI        <= '0;
      LO        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            DivByZero <= 1'b0;
            op_q      <= Op;
            cnt_q     <= '0;
            base_q    <= {HI, LO};
            neg_q     <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_q    <= signed_op && A[WIDTH-1];
            case (Op)
              OpMthi: begin
                HI   <= A;
                Done <= 1'b1;
              end
              OpMtlo: begin
                LO   <= A;
                Done <= 1'b1;
              end
              OpDiv, OpDivu: begin
                if (B == '0) begin
                  // No iteration; flag completes immediately with HI/LO untouched.
                  DivByZero <= 1'b1;
                  Done      <= 1'b1;
                end else begin
                  acc_q   <= {{WIDTH{1'b0}}, abs_a};
                  opb_q   <= abs_b;
                  state_q <= StDiv;
                end
              end
              default: begin
                acc_q   <= {{WIDTH{1'b0}}, abs_b};
                opa_q   <= abs_a;
                state_q <= StMul;
              end
            endcase
          end
        end
        StMul: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= StFix;
        end
        StDiv: begin
          // Restoring step: keep the trial subtraction only if it did not borrow.
          if (!div_diff[WIDTH]) begin
            acc_q <= {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= StFix;
        end
        StFix: begin
          if (is_div_q) begin
            LO <= quo;
            HI <= rem;
          end else begin
            {HI, LO} <= mul_res;
          end
          Done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO are queued when an op is
// issued and popped when Done is observed.
module tb_muldiv_sequencer;

  localparam int W = 32;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, MADD = 3'b010, MSUB = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, MTHI = 3'b110, MTLO = 3'b111;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   Op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] HI, LO;
  logic         Busy, Done, DivByZero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  // Present a request for exactly one accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; Op = $urandom_range(0, 7); A = $urandom; B = $urandom;
  endtask

  // Wait (bounded) for Done; latency is the cycle index of Done, -1 on timeout.
  task automatic wait_done(output int busy_cycles, output int latency);
    busy_cycles = 0;
    latency = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      if (Busy) busy_cycles++;
      if (Done) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_cycles, output int latency);
    start_op(op, a, b);
    wait_done(busy_cycles, latency);
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({HI, LO, Busy, Done, DivByZero} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got HI=%h LO=%h Busy=%b Done=%b DBZ=%b, want all 0",
               HI, LO, Busy, Done, DivByZero);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_mul(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] xh, input logic [W-1:0] xl);
    int bc, lat;
    sb.push_back('{hi: xh, lo: xl});
    run_op(op, a, b, bc, lat);
    e = sb.pop_front();
    vectors++;
    if (bc !== 33 || lat !== 34) begin
      miscompares++;
      $display("FAIL %s_timing: busy=%0d done_at=%0d, want busy=33 done_at=34", name, bc, lat);
    end
    vectors++;
    if (HI !== e.hi || LO !== e.lo) begin
      miscompares++;
      $display("FAIL %s_result: HI=%h LO=%h, want HI=%h LO=%h", name, HI, LO, e.hi, e.lo);
    end
    @(negedge Clk);
    vectors++;
    if (Done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_single_done: Done=%b one cycle later, want 0", name, Done);
    end
  endtask

  task automatic test_mt(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] xh, input logic [W-1:0] xl);
    int bc, lat;
    sb.push_back('{hi: xh, lo: xl});
    run_op(op, a, '0, bc, lat);
    e = sb.pop_front();
    vectors++;
    if (bc !== 0 || lat !== 1 || HI !== e.hi || LO !== e.lo || DivByZero !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy=%0d done_at=%0d HI=%h LO=%h DBZ=%b, want 0/1 HI=%h LO=%h DBZ=0",
               name, bc, lat, HI, LO, DivByZero, e.hi, e.lo);
    end
  endtask

  task automatic test_madd_msub();
    test_mt("mthi_keeps_lo", MTHI, 32'h0, 32'h0, 32'h0000_0001);
    test_mt("mtlo", MTLO, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
    test_mul("madd", MADD, 32'd1, 32'd1, 32'h1, 32'h0);
    test_mt("mthi0", MTHI, 32'h0, 32'h0, 32'h0);
    test_mt("mtlo0", MTLO, 32'h0, 32'h0, 32'h0);
    test_mul("msub", MSUB, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
  endtask

  task automatic test_div_by_zero();
    int bc, lat;
    sb.push_back('{hi: HI, lo: LO});
    run_op(DIVU, 32'd7, 32'd0, bc, lat);
    e = sb.pop_front();
    vectors++;
    if (bc !== 0 || lat !== 1 || DivByZero !== 1'b1 || HI !== e.hi || LO !== e.lo) begin
      miscompares++;
      $display("FAIL div_by_zero: busy=%0d done_at=%0d DBZ=%b HI=%h LO=%h, want 0/1/1 HI=%h LO=%h",
               bc, lat, DivByZero, HI, LO, e.hi, e.lo);
    end
    test_mt("mtlo_clears_dbz", MTLO, 32'd5, e.hi, 32'd5);
  endtask

  task automatic test_busy_ignore();
    int bc, lat, dones;
    logic [W-1:0] hold_hi, hold_lo;
    hold_hi = HI;
    hold_lo = LO;
    sb.push_back('{hi: 32'h0, lo: 32'd30});
    start_op(MULT, 32'd5, 32'd6);
    bc = 0; lat = -1; dones = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge Clk);
      if (Busy) bc++;
      if (Done) begin
        dones++;
        if (lat < 0) lat = i;
      end
      if (i == 5) begin
        Start = 1'b1; Op = DIVU; A = 32'd9; B = 32'd3;
        @(posedge Clk);
        #1 Start = 1'b0;
      end
      if (i == 20) begin
        vectors++;
        if (HI !== hold_hi || LO !== hold_lo) begin
          miscompares++;
          $display("FAIL hilo_stable: HI=%h LO=%h mid-op, want HI=%h LO=%h",
                   HI, LO, hold_hi, hold_lo);
        end
      end
    end
    e = sb.pop_front();
    vectors++;
    if (bc !== 33 || lat !== 34 || dones !== 1) begin
      miscompares++;
      $display("FAIL busy_ignore_timing: busy=%0d done_at=%0d dones=%0d, want 33/34/1",
               bc, lat, dones);
    end
    vectors++;
    if (HI !== e.hi || LO !== e.lo) begin
      miscompares++;
      $display("FAIL busy_ignore_result: HI=%h LO=%h, want HI=%h LO=%h", HI, LO, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_abort();
    sb.push_back('{hi: 32'd2, lo: 32'd14});
    start_op(DIV, 32'd100, 32'd7);
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    void'(sb.pop_front());  // aborted op never produces a result
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || HI !== '0 || LO !== '0) begin
      miscompares++;
      $display("FAIL reset_abort: Busy=%b Done=%b HI=%h LO=%h, want all 0", Busy, Done, HI, LO);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    test_mul("after_reset", MULTU, 32'd4, 32'd4, 32'h0, 32'd16);
  endtask

  initial begin
    test_reset();
    test_mul("mult", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    test_mul("multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    test_madd_msub();
    test_mul("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_mul("div_wrap", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    test_mul("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    test_div_by_zero();
    test_busy_ignore();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit for the MIPS datapath. It owns the architectural HI/LO registers.
- It replaces the single-cycle combinational mult/madd/msub paths in the ALU with iterative sequencing: shift-add multiply and restoring divide.
- It drives Busy into the hazard unit so the pipeline stalls on mfhi/mflo, or on a new muldiv op, while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  request; sampled only in IDLE
Op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO
A  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
B  in  WIDTH  rt operand (multiplier/divisor)
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register
Busy  out  1  high whenever state != IDLE
Done  out  1  one-cycle registered pulse when HI/LO are written, or when a divide-by-zero completes
DivByZero  out  1  set when DIV/DIVU starts with B==0; cleared on the next accepted Start

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0, all internal registers cleared. Reset mid-operation aborts it with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- Start accepted (IDLE, Start=1, edge t):
  - Latches Op, A, B, and for MADD/MSUB the current {HI,LO}.
  - Signed ops (MULT/MADD/MSUB/DIV) latch magnitudes |A|, |B| plus result-sign flags.
  - Clears DivByZero.
- MTHI/MTLO: complete at edge t. HI<=A (MTHI) or LO<=A (MTLO); the other register is unchanged. Done=1 during cycle t+1. Busy never rises.
- Multiply ops:
  - IDLE->MUL at t. One shift-add iteration per edge for WIDTH edges (t+1..t+32). MUL->FIX at edge t+32.
  - At edge t+33 FIX writes HI/LO and goes to IDLE.
  - FIX negates the 2*WIDTH product if signs differ (MULT/MADD/MSUB only).
  - MADD: adds the latched {HI,LO}; MSUB: subtracts the product from it. Both wrap modulo 2^64.
  - Busy is high for cycles t+1..t+33; Done=1 during cycle t+34.
- DIV/DIVU with B!=0:
  - Restoring division, WIDTH iterations in DIV, then FIX. Same timing as multiply.
  - LO=quotient, HI=remainder.
  - Signed: quotient negated if signs of A and B differ; remainder takes the sign of A.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (natural wrap, no trap).
- DIV/DIVU with B==0: no iteration. At edge t DivByZero<=1 and state stays IDLE; Done=1 during t+1. HI/LO unchanged, Busy never rises.
- Start while Busy: ignored, no queueing. Hazard logic must hold the instruction.
- Op outside the Start cycle: don't-care. A/B may change freely after acceptance.
- HI/LO outputs are stable, holding old values, throughout an operation; they change only on the FIX/MT edge.

Test Plan:
1. MULT A=0xFFFFFFFD, B=7, Start 1 cycle -> Busy high 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; exactly one Done pulse.
2. MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. Two MADD/MSUB sequences:
   - Preload via MTHI 0, MTLO 0xFFFFFFFF, then MADD A=1, B=1 -> HI=1, LO=0.
   - From HI=LO=0, MSUB A=2, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
4. Three divides:
   - DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
   - DIVU A=7, B=0 -> Done next cycle, DivByZero=1, Busy stays 0, HI/LO unchanged; a following MTLO clears DivByZero.
5. Start MULT 5*6; at busy cycle 5 pulse Start with DIVU 9/3 -> ignored; final HI=0, LO=30; one Done only.
6. Start DIV 100/7; drive Reset=0 at busy cycle 10 (between edges) -> Busy, Done, HI, LO go to 0 immediately. After release, MULTU 4*4 gives LO=16 with normal 33-cycle latency.
